// File: rtl/lab_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab_pkg
// Description : Shared debounce state encoding and default constants.
// Revision    : 1.0 - initial release
// ============================================================================
package lab_pkg;

    localparam logic [1:0] STABLE_LOW  = 2'b00;
    localparam logic [1:0] WAIT_HIGH   = 2'b01;
    localparam logic [1:0] STABLE_HIGH = 2'b11;
    localparam logic [1:0] WAIT_LOW    = 2'b10;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : STAGES-deep flop synchronizer for an asynchronous input.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/btn_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_pulse
// Description : Synchronizes and debounces a raw button, giving a clean level
//               plus single-cycle rise/fall pulses and a qualification flag.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_pulse
    import lab_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int             CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_sync;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (w_sync)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            STABLE_LOW: begin
                w_cnt_nxt = '0;
                if (w_sync) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = STABLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = STABLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            STABLE_HIGH: begin
                w_cnt_nxt = '0;
                if (!w_sync) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT_LOW: begin
                if (w_sync) begin
                    w_state_nxt = STABLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = STABLE_LOW;
                    w_cnt_nxt   = '0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = STABLE_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with the state flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= (w_state_nxt == STABLE_HIGH) || (w_state_nxt == WAIT_LOW);
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= (w_state_nxt == WAIT_HIGH) || (w_state_nxt == WAIT_LOW);
        end
    end

    assign level_out  = r_level;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = r_busy;

endmodule
`default_nettype wire
